controlador_memoria: RTL and testbench
======================================

# controlador_memoria

Word-addressed memory responder serving the multicycle control unit's memory requests. It accepts one read or write request at a time over a request/ready handshake and completes it after a programmable number of wait cycles. It owns a local array of `DEPTH_WORDS` 32-bit words and flags misaligned or out-of-range addresses. It sits between the control unit/datapath (request side) and the instruction/data registers that load `DataOut`.

## Interface
- `LATENCY`, default 2: wait cycles from request acceptance to commit; legal range 1..15.
- `DEPTH_WORDS`, default 64: number of 32-bit words; power of two, 2..1024.

Ports:
- `clock`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Req`  in  1  request strobe; sampled only in IDLE.
- `WriteMem`  in  1  1 = write, 0 = read; sampled with `Req`.
- `Address`  in  32  byte address; sampled with `Req`.
- `DataIn`  in  32  write data; sampled with `Req`.
- `DataOut`  out  32  last successfully read word.
- `Ready`  out  1  one-cycle completion pulse.
- `AddrErr`  out  1  error status of the completing request; valid while `Ready`=1.
- `Busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ACCESS, RESPOND. Outputs are Moore (registered state only).
- IDLE, `Req`=1 at an edge: latch `WriteMem`, `Address`, `DataIn`.
  - Error check: `Address[1:0]`≠0, or word index `Address[31:2]` ≥ `DEPTH_WORDS`. On error, go to RESPOND with the error flag set. No array access occurs and `DataOut` is unchanged.
  - Otherwise go to ACCESS and load the wait counter with `LATENCY-1`.
- ACCESS:
  - If counter≠0, decrement it.
  - If counter=0, commit and go to RESPOND:
    - write: array[index] ← latched data;
    - read: `DataOut` ← array[index].
- RESPOND: `Ready`=1 and `AddrErr`=error flag; next edge returns to IDLE unconditionally.
- `Req` in ACCESS or RESPOND is ignored and is not queued. Inputs changing after acceptance have no effect.
- Writes never alter `DataOut`. A read of an address in the same request as a write is impossible, since requests are serialized. A read after a write to the same index returns the new data.
- Array contents are not cleared by reset and are undefined until written.
- Reset asserted mid-operation: state returns to IDLE and outputs return to reset values. A write not yet committed is discarded. A write committed on an earlier edge persists.

## Timing
- Reset values: state IDLE, `DataOut`=0, `Ready`=0, `AddrErr`=0, `Busy`=0, counter=0, error flag=0.
- Valid request accepted at edge E0:
  - `Busy`=1 after E0;
  - commit at edge E0+`LATENCY`;
  - `Ready`=1 (with read data on `DataOut`) during the cycle after E0+`LATENCY`;
  - IDLE after E0+`LATENCY`+1.
- Errored request at E0: `Ready`=`AddrErr`=1 during the cycle after E0; IDLE after E0+1.
- Earliest next acceptance is E0+`LATENCY`+2 for a valid request and E0+2 for an errored one.
- `AddrErr` is 0 whenever `Ready`=0.
- `DataOut` holds its value indefinitely between reads.

## Test plan
- Reset then write/read, `LATENCY`=2: write 0xDEADBEEF to 0x10 with `Req` at E0. Required: `Ready` high only in the cycle after E2. Then read 0x10: `DataOut`=0xDEADBEEF with `Ready`, and `AddrErr`=0 both times.
- Misaligned: read 0x13 with `DataOut` previously 0xDEADBEEF. Required: `Ready`=`AddrErr`=1 in the cycle after acceptance, `DataOut` stays 0xDEADBEEF, and a later read of 0x10 still returns 0xDEADBEEF.
- Out of range, `DEPTH_WORDS`=64: write 0x100 (index 64). Required: `AddrErr`=1 with `Ready`. Address 0xFC (index 63) write/read of 0x12345678 succeeds.
- Busy ignore: hold `Req`=1 continuously with a write of 0xAAAA0001 to 0x0 and a read of 0x4 presented during ACCESS. Required: only the write completes. `Req` still high at the next IDLE edge starts a new request sampled at that edge.
- Reset mid-write: write 0x55555555 to 0x8 (old 0x11111111). Assert `reset` low after E1 (before commit). Required: all outputs at reset values immediately. A subsequent read of 0x8 returns 0x11111111.
- `LATENCY`=1 back-to-back: two reads accepted at E0 and E3. Required: `Ready` in the cycles after E1 and E4, `Busy` low only during the cycle after E2.

Source files
------------

// File: rtl/controlador_memoria_if.sv
// Request/response bundle between the multicycle control unit and the memory responder.
`timescale 1ns/1ps
interface controlador_memoria_if;
    logic        Req;
    logic        WriteMem;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        Ready;
    logic        AddrErr;
    logic        Busy;

    modport master (
        output Req, WriteMem, Address, DataIn,
        input  DataOut, Ready, AddrErr, Busy
    );

    modport slave (
        input  Req, WriteMem, Address, DataIn,
        output DataOut, Ready, AddrErr, Busy
    );
endinterface

// File: rtl/controlador_memoria.sv
// Word-addressed memory responder: one request at a time, committed after LATENCY wait cycles,
// with misaligned / out-of-range addresses reported instead of accessing the array.
`timescale 1ns/1ps
module controlador_memoria #(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    controlador_memoria_if.slave  bus
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned DW    = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [DW-1:0]      dout_q, dout_d;
    logic               ready_q, ready_d;
    logic               addr_err_q, addr_err_d;
    logic               busy_q, busy_d;
    logic               mem_we_c;
    logic               addr_bad_c;

    // Storage is intentionally not reset; contents are undefined until written.
    logic [DW-1:0]      mem_q [DEPTH_WORDS];

    assign addr_bad_c = (bus.Address[1:0] != 2'b00) ||
                        ({2'b00, bus.Address[31:2]} >= 32'(DEPTH_WORDS));

    // Next-state, commit and Moore output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        dout_d   = dout_q;
        mem_we_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Req) begin
                    wr_d    = bus.WriteMem;
                    wdata_d = bus.DataIn;
                    idx_d   = bus.Address[IDX_W+1:2];
                    err_d   = addr_bad_c;
                    if (addr_bad_c) begin
                        state_d = RESPOND;
                        cnt_d   = '0;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RESPOND;
                    if (wr_q) mem_we_c = 1'b1;
                    else      dout_d   = mem_q[idx_q];
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d    = (state_d == RESPOND);
        addr_err_d = ready_d && err_d;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            dout_q     <= '0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
            ready_q    <= ready_d;
            addr_err_q <= addr_err_d;
            busy_q     <= busy_d;
        end
    end

    // Write port; only reachable from ACCESS, so reset discards uncommitted writes.
    always_ff @(posedge clock) begin
        if (mem_we_c) mem_q[idx_q] <= wdata_q;
    end

    assign bus.DataOut = dout_q;
    assign bus.Ready   = ready_q;
    assign bus.AddrErr = addr_err_q;
    assign bus.Busy    = busy_q;

endmodule

// File: tb/tb_controlador_memoria.sv
// Self-checking bench for controlador_memoria: directed scenarios plus randomized traffic
// checked against a word-array reference model.
`timescale 1ns/1ps
module tb_controlador_memoria;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 2;

    logic clock;
    logic reset;

    controlador_memoria_if bus ();
    controlador_memoria_if bus1 ();

    controlador_memoria #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    controlador_memoria #(.LATENCY(1), .DEPTH_WORDS(DEPTH)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Reference model for the LATENCY=2 instance.
    logic [31:0] model_mem [DEPTH];
    bit          model_vld [DEPTH];
    logic [31:0] model_dout;

    function automatic bit exp_err(input logic [31:0] addr);
        return (addr % 4 != 0) || ((addr / 4) >= DEPTH);
    endfunction

    function automatic void model_apply(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        if (!exp_err(addr)) begin
            if (wr) begin
                model_mem[addr / 4] = data;
                model_vld[addr / 4] = 1'b1;
            end else begin
                model_dout = model_mem[addr / 4];
            end
        end
    endfunction

    // Issue one request on the LATENCY=2 instance and report what was observed.
    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           output int rc, output logic err_o, output logic [31:0] dout_o,
                           output logic busy_e0, output logic busy_end, output logic ready_end,
                           output logic leak);
        @(negedge clock);
        bus.Req = 1'b1; bus.WriteMem = wr; bus.Address = addr; bus.DataIn = data;
        @(negedge clock);
        bus.Req = 1'b0; bus.WriteMem = 1'($urandom); bus.Address = $urandom; bus.DataIn = $urandom;
        busy_e0 = bus.Busy;
        leak = 1'b0;
        rc = 1;
        while (bus.Ready !== 1'b1 && rc < 20) begin
            if (bus.AddrErr !== 1'b0) leak = 1'b1;
            @(negedge clock);
            rc++;
        end
        if (bus.Ready !== 1'b1) rc = 0;
        err_o  = bus.AddrErr;
        dout_o = bus.DataOut;
        @(negedge clock);
        busy_end  = bus.Busy;
        ready_end = bus.Ready;
    endtask

    // Fixed-timing write on the LATENCY=1 instance (accept, commit, respond, idle).
    task automatic req1(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        bus1.Req = 1'b1; bus1.WriteMem = wr; bus1.Address = addr; bus1.DataIn = data;
        @(negedge clock);
        bus1.Req = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.Req = 1'b0; bus.WriteMem = 1'b0; bus.Address = '0; bus.DataIn = '0;
        bus1.Req = 1'b0; bus1.WriteMem = 1'b0; bus1.Address = '0; bus1.DataIn = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        model_dout = '0;
        check_cnt++; if (bus.DataOut !== 32'h0) $display("FAIL reset_dataout got=%h want=0", bus.DataOut); else pass_cnt++;
        check_cnt++; if ({bus.Ready, bus.AddrErr, bus.Busy} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {bus.Ready, bus.AddrErr, bus.Busy}); else pass_cnt++;
        check_cnt++; if ({bus1.Ready, bus1.AddrErr, bus1.Busy, |bus1.DataOut} !== 4'b0000) $display("FAIL reset_lat1 got=%b want=0000", {bus1.Ready, bus1.AddrErr, bus1.Busy, |bus1.DataOut}); else pass_cnt++;
    endtask

    task automatic test_write_read();
        int rc; logic e, b0, be, re, lk; logic [31:0] d;
        run_req(1'b1, 32'h10, 32'hDEADBEEF, rc, e, d, b0, be, re, lk);
        model_apply(1'b1, 32'h10, 32'hDEADBEEF);
        check_cnt++; if (rc !== LAT + 1) $display("FAIL wr_ready_cycle got=%0d want=%0d", rc, LAT + 1); else pass_cnt++;
        check_cnt++; if ({e, b0, be, re, lk} !== 5'b01000) $display("FAIL wr_flags got=%b want=01000", {e, b0, be, re, lk}); else pass_cnt++;
        check_cnt++; if (d !== model_dout) $display("FAIL wr_dataout_unchanged got=%h want=%h", d, model_dout); else pass_cnt++;
        run_req(1'b0, 32'h10, 32'h0, rc, e, d, b0, be, re, lk);
        model_apply(1'b0, 32'h10, 32'h0);
        check_cnt++; if (rc !== LAT + 1) $display("FAIL rd_ready_cycle got=%0d want=%0d", rc, LAT + 1); else pass_cnt++;
        check_cnt++; if (d !== 32'hDEADBEEF) $display("FAIL rd_data got=%h want=deadbeef", d); else pass_cnt++;
        check_cnt++; if ({e, be, re, lk} !== 4'b0000) $display("FAIL rd_flags got=%b want=0000", {e, be, re, lk}); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        int rc; logic e, b0, be, re, lk; logic [31:0] d;
        run_req(1'b0, 32'h13, 32'h0, rc, e, d, b0, be, re, lk);
        check_cnt++; if (rc !== 1) $display("FAIL mis_ready_cycle got=%0d want=1", rc); else pass_cnt++;
        check_cnt++; if ({e, be} !== 2'b10) $display("FAIL mis_err got=%b want=10", {e, be}); else pass_cnt++;
        check_cnt++; if (d !== 32'hDEADBEEF) $display("FAIL mis_dataout got=%h want=deadbeef", d); else pass_cnt++;
        run_req(1'b0, 32'h10, 32'h0, rc, e, d, b0, be, re, lk);
        model_apply(1'b0, 32'h10, 32'h0);
        check_cnt++; if (d !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL mis_reread got=%h/%b want=deadbeef/0", d, e); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        int rc; logic e, b0, be, re, lk; logic [31:0] d;
        run_req(1'b1, 32'h100, 32'hCAFE0000, rc, e, d, b0, be, re, lk);
        check_cnt++; if (rc !== 1 || e !== 1'b1) $display("FAIL oor_err got=%0d/%b want=1/1", rc, e); else pass_cnt++;
        run_req(1'b1, 32'hFC, 32'h12345678, rc, e, d, b0, be, re, lk);
        model_apply(1'b1, 32'hFC, 32'h12345678);
        check_cnt++; if (rc !== LAT + 1 || e !== 1'b0) $display("FAIL top_wr got=%0d/%b want=%0d/0", rc, e, LAT + 1); else pass_cnt++;
        run_req(1'b0, 32'hFC, 32'h0, rc, e, d, b0, be, re, lk);
        model_apply(1'b0, 32'hFC, 32'h0);
        check_cnt++; if (d !== 32'h12345678 || e !== 1'b0) $display("FAIL top_rd got=%h/%b want=12345678/0", d, e); else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        int rc; logic e, b0, be, re, lk; logic [31:0] d, w4;
        w4 = $urandom;
        run_req(1'b1, 32'h4, w4, rc, e, d, b0, be, re, lk);
        model_apply(1'b1, 32'h4, w4);
        @(negedge clock);
        bus.Req = 1'b1; bus.WriteMem = 1'b1; bus.Address = 32'h0; bus.DataIn = 32'hAAAA0001;
        @(negedge clock);
        bus.WriteMem = 1'b0; bus.Address = 32'h4; bus.DataIn = $urandom;
        check_cnt++; if ({bus.Busy, bus.Ready} !== 2'b10) $display("FAIL bi_e0 got=%b want=10", {bus.Busy, bus.Ready}); else pass_cnt++;
        @(negedge clock);
        check_cnt++; if (bus.Ready !== 1'b0) $display("FAIL bi_e1_ready got=%b want=0", bus.Ready); else pass_cnt++;
        @(negedge clock);
        model_apply(1'b1, 32'h0, 32'hAAAA0001);
        check_cnt++; if ({bus.Ready, bus.AddrErr} !== 2'b10 || bus.DataOut !== model_dout) $display("FAIL bi_wr_done got=%b/%h want=10/%h", {bus.Ready, bus.AddrErr}, bus.DataOut, model_dout); else pass_cnt++;
        @(negedge clock);
        check_cnt++; if ({bus.Busy, bus.Ready} !== 2'b00) $display("FAIL bi_idle got=%b want=00", {bus.Busy, bus.Ready}); else pass_cnt++;
        @(negedge clock);
        bus.Req = 1'b0;
        check_cnt++; if (bus.Busy !== 1'b1) $display("FAIL bi_reaccept got=%b want=1", bus.Busy); else pass_cnt++;
        repeat (2) @(negedge clock);
        model_apply(1'b0, 32'h4, 32'h0);
        check_cnt++; if (bus.Ready !== 1'b1 || bus.DataOut !== model_dout) $display("FAIL bi_rd got=%b/%h want=1/%h", bus.Ready, bus.DataOut, model_dout); else pass_cnt++;
        run_req(1'b0, 32'h0, 32'h0, rc, e, d, b0, be, re, lk);
        model_apply(1'b0, 32'h0, 32'h0);
        check_cnt++; if (d !== 32'hAAAA0001) $display("FAIL bi_word0 got=%h want=aaaa0001", d); else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        int rc; logic e, b0, be, re, lk; logic [31:0] d;
        run_req(1'b1, 32'h8, 32'h11111111, rc, e, d, b0, be, re, lk);
        model_apply(1'b1, 32'h8, 32'h11111111);
        @(negedge clock);
        bus.Req = 1'b1; bus.WriteMem = 1'b1; bus.Address = 32'h8; bus.DataIn = 32'h55555555;
        @(negedge clock);
        bus.Req = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check_cnt++; if ({bus.Ready, bus.AddrErr, bus.Busy} !== 3'b000 || bus.DataOut !== 32'h0) $display("FAIL rst_mid got=%b/%h want=000/0", {bus.Ready, bus.AddrErr, bus.Busy}, bus.DataOut); else pass_cnt++;
        @(negedge clock);
        reset = 1'b1;
        model_dout = '0;
        run_req(1'b0, 32'h8, 32'h0, rc, e, d, b0, be, re, lk);
        model_apply(1'b0, 32'h8, 32'h0);
        check_cnt++; if (d !== 32'h11111111) $display("FAIL rst_discard got=%h want=11111111", d); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] va, vb;
        va = $urandom; vb = $urandom;
        req1(1'b1, 32'h20, va);
        req1(1'b1, 32'h24, vb);
        @(negedge clock);
        bus1.Req = 1'b1; bus1.WriteMem = 1'b0; bus1.Address = 32'h20;
        @(negedge clock);
        bus1.Req = 1'b0;
        check_cnt++; if ({bus1.Busy, bus1.Ready} !== 2'b10) $display("FAIL b2b_e0 got=%b want=10", {bus1.Busy, bus1.Ready}); else pass_cnt++;
        @(negedge clock);
        check_cnt++; if ({bus1.Busy, bus1.Ready, bus1.AddrErr} !== 3'b110 || bus1.DataOut !== va) $display("FAIL b2b_rd1 got=%b/%h want=110/%h", {bus1.Busy, bus1.Ready, bus1.AddrErr}, bus1.DataOut, va); else pass_cnt++;
        @(negedge clock);
        check_cnt++; if ({bus1.Busy, bus1.Ready} !== 2'b00) $display("FAIL b2b_gap got=%b want=00", {bus1.Busy, bus1.Ready}); else pass_cnt++;
        bus1.Req = 1'b1; bus1.Address = 32'h24;
        @(negedge clock);
        bus1.Req = 1'b0;
        check_cnt++; if ({bus1.Busy, bus1.Ready} !== 2'b10) $display("FAIL b2b_e3 got=%b want=10", {bus1.Busy, bus1.Ready}); else pass_cnt++;
        @(negedge clock);
        check_cnt++; if ({bus1.Busy, bus1.Ready} !== 2'b11 || bus1.DataOut !== vb) $display("FAIL b2b_rd2 got=%b/%h want=11/%h", {bus1.Busy, bus1.Ready}, bus1.DataOut, vb); else pass_cnt++;
        @(negedge clock);
        check_cnt++; if ({bus1.Busy, bus1.Ready} !== 2'b00 || bus1.DataOut !== vb) $display("FAIL b2b_hold got=%b/%h want=00/%h", {bus1.Busy, bus1.Ready}, bus1.DataOut, vb); else pass_cnt++;
    endtask

    task automatic test_random();
        int rc; logic e, b0, be, re, lk; logic [31:0] d, addr, data; logic wr; bit xe;
        for (int i = 0; i < 30; i++) begin
            addr = 32'($urandom_range(0, 71)) * 4;
            if ($urandom_range(0, 5) == 0) addr = addr + 32'($urandom_range(1, 3));
            data = $urandom;
            wr = 1'($urandom);
            xe = exp_err(addr);
            if (!xe && !model_vld[addr / 4]) wr = 1'b1;
            run_req(wr, addr, data, rc, e, d, b0, be, re, lk);
            model_apply(wr, addr, data);
            check_cnt++; if (rc !== (xe ? 1 : LAT + 1) || e !== xe) $display("FAIL rand%0d_timing addr=%h got=%0d/%b want=%0d/%b", i, addr, rc, e, xe ? 1 : LAT + 1, xe); else pass_cnt++;
            check_cnt++; if (d !== model_dout) $display("FAIL rand%0d_data addr=%h got=%h want=%h", i, addr, d, model_dout); else pass_cnt++;
            check_cnt++; if ({b0, be, re, lk} !== 4'b1000) $display("FAIL rand%0d_flags got=%b want=1000", i, {b0, be, re, lk}); else pass_cnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_vld[i] = 1'b0;
        test_reset();
        test_write_read();
        test_misaligned();
        test_out_of_range();
        test_busy_ignore();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
